// File: rtl/gigatron_flash_fetch.sv
// gigatron_flash_fetch
//   Fetches 16-bit Gigatron ROM words from an 8-bit parallel NOR flash.
//   Each word is read as two bytes: even byte -> insn[7:0], odd byte -> insn[15:8].
//   Each byte address is held WAIT_CYCLES clocks before its data is sampled.
//   After reset release the block stays busy for STARTUP_CYCLES clocks so the
//   flash can come out of reset.
//
//   Optional build macro FLASH_FETCH_CACHE_EN adds a one-entry word cache.
//   A repeat request for the last flash-fetched word is then answered from the
//   cache with no flash traffic.
//
// Parameters
//   WAIT_CYCLES     clocks each byte address is held before sampling (1..15)
//   BASE_ADDR       flash byte address of ROM word 0
//   STARTUP_CYCLES  clocks after reset release before requests are accepted (1..255)
//
// Ports
//   CLOCK_50   in   system clock, rising edge
//   reset_n    in   synchronous active-low reset
//   req        in   single-cycle fetch request, addr sampled with it
//   addr       in   [15:0] ROM word address
//   insn       out  [15:0] fetched instruction word
//   insn_rdy   out  insn holds the result of the last accepted request
//   busy       out  request cannot be accepted
//   FL_ADDR    out  [21:0] flash byte address
//   FL_DQ      in   [7:0] flash data
//   FL_CE_N    out  flash chip enable (tied active)
//   FL_OE_N    out  flash output enable (tied active)
//   FL_WE_N    out  flash write enable (tied inactive)
//   FL_RST_N   out  flash reset, reset_n delayed one clock
//
// States
//   STARTUP | waiting STARTUP_CYCLES clocks after reset, busy
//   IDLE    | no result yet, ready for a request
//   LO_WAIT | even byte address on flash, waiting to sample
//   HI_WAIT | odd byte address on flash, waiting to sample
//   DONE    | insn valid and held, ready for a request

module gigatron_flash_fetch #(
  parameter int unsigned  WAIT_CYCLES    = 5,
  parameter logic [21:0]  BASE_ADDR      = 22'h000000,
  parameter int unsigned  STARTUP_CYCLES = 32
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  input  logic        req,
  input  logic [15:0] addr,
  output logic [15:0] insn,
  output logic        insn_rdy,
  output logic        busy,
  output logic [21:0] FL_ADDR,
  input  logic [7:0]  FL_DQ,
  output logic        FL_CE_N,
  output logic        FL_OE_N,
  output logic        FL_WE_N,
  output logic        FL_RST_N
);

  localparam logic [3:0] WAIT_LOAD  = 4'(WAIT_CYCLES - 1);
  localparam logic [7:0] START_LAST = 8'(STARTUP_CYCLES - 1);

  typedef enum logic [2:0] {
    STARTUP,
    IDLE,
    LO_WAIT,
    HI_WAIT,
    DONE
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [7:0]  r_start_cnt;
  logic [3:0]  r_wait_cnt;
  logic [15:0] r_insn;
  logic        r_insn_rdy;
  logic [21:0] r_fl_addr;
  logic        r_fl_rst_n;

  logic        w_accept;
  logic        w_hit;
  logic        w_lo_done;
  logic        w_hi_done;
  logic        w_cache_hit;
  logic        w_hit_pend;
  logic [15:0] w_cache_data;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      r_state <= STARTUP;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_hit       = 1'b0;
    w_lo_done   = 1'b0;
    w_hi_done   = 1'b0;
    case (r_state)
      STARTUP: begin
        if (r_start_cnt == START_LAST) begin
          w_state_nxt = IDLE;
        end
      end
      IDLE, DONE: begin
        if (req) begin
          w_accept = 1'b1;
          if (w_cache_hit) begin
            w_hit       = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = LO_WAIT;
          end
        end
      end
      LO_WAIT: begin
        if (r_wait_cnt == 4'd0) begin
          w_lo_done   = 1'b1;
          w_state_nxt = HI_WAIT;
        end
      end
      HI_WAIT: begin
        if (r_wait_cnt == 4'd0) begin
          w_hi_done   = 1'b1;
          w_state_nxt = DONE;
        end
      end
      default: begin
        w_state_nxt = STARTUP;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      r_start_cnt <= 8'd0;
    end else if (r_state == STARTUP) begin
      r_start_cnt <= r_start_cnt + 8'd1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      r_insn     <= 16'h0000;
      r_insn_rdy <= 1'b0;
      r_fl_addr  <= 22'h0;
      r_wait_cnt <= 4'd0;
    end else if (w_accept) begin
      r_insn_rdy <= 1'b0;
      if (!w_hit) begin
        // Modulo-2^22 wrap falls out of the 22-bit add.
        r_fl_addr  <= BASE_ADDR + {5'b0, addr, 1'b0};
        r_wait_cnt <= WAIT_LOAD;
      end
    end else if (w_hit_pend) begin
      // Cache hits present their data one clock after acceptance.
      r_insn     <= w_cache_data;
      r_insn_rdy <= 1'b1;
    end else if (w_lo_done) begin
      r_insn[7:0]  <= FL_DQ;
      r_fl_addr[0] <= 1'b1;
      r_wait_cnt   <= WAIT_LOAD;
    end else if (w_hi_done) begin
      r_insn[15:8] <= FL_DQ;
      r_insn_rdy   <= 1'b1;
    end else if (r_state == LO_WAIT || r_state == HI_WAIT) begin
      r_wait_cnt <= r_wait_cnt - 4'd1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    r_fl_rst_n <= reset_n;
  end

  // ---------------------------------------------------------------------------
  // Optional one-entry cache
  // ---------------------------------------------------------------------------
`ifdef FLASH_FETCH_CACHE_EN
  logic        r_valid;
  logic [15:0] r_tag;
  logic [15:0] r_data;
  logic [15:0] r_req_addr;
  logic        r_hit_pend;

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      r_valid    <= 1'b0;
      r_tag      <= 16'h0000;
      r_data     <= 16'h0000;
      r_req_addr <= 16'h0000;
      r_hit_pend <= 1'b0;
    end else begin
      r_hit_pend <= w_accept && w_hit;
      if (w_accept && !w_hit) begin
        r_req_addr <= addr;
      end
      // Fill uses the byte being captured this edge plus the stored low byte.
      if (w_hi_done) begin
        r_tag   <= r_req_addr;
        r_data  <= {FL_DQ, r_insn[7:0]};
        r_valid <= 1'b1;
      end
    end
  end

  assign w_cache_hit  = r_valid && (addr == r_tag);
  assign w_hit_pend   = r_hit_pend;
  assign w_cache_data = r_data;
`else
  assign w_cache_hit  = 1'b0;
  assign w_hit_pend   = 1'b0;
  assign w_cache_data = 16'h0000;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // reset_n is folded in so busy is high for the whole reset, not just after
  // the first reset edge.
  assign busy     = !reset_n || (r_state == STARTUP) ||
                    (r_state == LO_WAIT) || (r_state == HI_WAIT);
  assign insn     = r_insn;
  assign insn_rdy = r_insn_rdy;
  assign FL_ADDR  = r_fl_addr;
  assign FL_CE_N  = 1'b0;
  assign FL_OE_N  = 1'b0;
  assign FL_WE_N  = 1'b1;
  assign FL_RST_N = r_fl_rst_n;

endmodule
